// File: rtl/diff_chain_stage.sv
// diff_chain_stage: chains per-lane backprop derivatives through one shared
// fixed-point multiplier. Lanes are processed one per cycle, first
// start*dense, then optionally acc*cost, with valid/ready on both sides.
module diff_chain_stage #(
   parameter int size            = 3,
   parameter int data_size       = 16,
   parameter int frac_bits       = 8,
   parameter int dense_type_size = 4
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [31:0]                     w_layer_index,
   input  logic [31:0]                     w_row_index,
   input  logic                            backprop_cost,
   input  logic [size*data_size-1:0]       diff_start,
   input  logic [size*data_size-1:0]       diff_dense,
   input  logic [size*data_size-1:0]       diff_cost,
   input  logic [dense_type_size-1:0]      dense_type,
   input  logic                            is_update,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [31:0]                     w_layer_index_out,
   output logic [31:0]                     w_row_index_out,
   output logic                            backprop_cost_out,
   output logic                            is_update_out,
   output logic [dense_type_size-1:0]      dense_type_out,
   output logic [size*data_size-1:0]       diff_to_all_out
);

   localparam int CW = (size > 1) ? $clog2(size) : 1;
   localparam int PW = 2 * data_size;

   typedef enum logic [1:0] {IDLE, MUL_DENSE, MUL_COST, DONE} state_t;

   state_t                              r_state;
   state_t                              w_next;
   logic [CW-1:0]                       r_cnt;
   logic [size-1:0][data_size-1:0]      r_start;
   logic [size-1:0][data_size-1:0]      r_dense;
   logic [size-1:0][data_size-1:0]      r_cost;
   logic [size-1:0][data_size-1:0]      r_acc;

   logic                                w_accept;
   logic                                w_last;
   logic                                w_mul;
   logic signed [data_size-1:0]         w_op_a;
   logic signed [data_size-1:0]         w_op_b;
   logic signed [PW-1:0]                w_prod;
   logic signed [PW-1:0]                w_shift;
   logic [data_size-1:0]                w_sat;

   assign in_ready        = (r_state == IDLE);
   assign out_valid       = (r_state == DONE);
   assign w_accept        = in_valid && (r_state == IDLE);
   assign w_last          = (r_cnt == CW'(size - 1));
   assign w_mul           = (r_state == MUL_DENSE) || (r_state == MUL_COST);
   assign diff_to_all_out = r_acc;

   // State register
   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   // Next-state: sweep dense lanes, then cost lanes if requested, then hold
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:      if (in_valid) w_next = MUL_DENSE;
         MUL_DENSE: if (w_last)   w_next = backprop_cost_out ? MUL_COST : DONE;
         MUL_COST:  if (w_last)   w_next = DONE;
         DONE:      if (out_ready) w_next = IDLE;
         default:   w_next = IDLE;
      endcase
   end

   // Lane counter: restarts on accept and at the end of each lane sweep
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (r_state == IDLE) begin
         r_cnt <= '0;
      end else if (w_mul) begin
         r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      end
   end

   // Operand select for the shared multiplier; first pass uses start, second uses acc
   always_comb begin
      w_op_a = '0;
      w_op_b = '0;
      for (int k = 0; k < size; k++) begin
         if (r_cnt == CW'(k)) begin
            w_op_a = (r_state == MUL_COST) ? r_acc[k]  : r_start[k];
            w_op_b = (r_state == MUL_COST) ? r_cost[k] : r_dense[k];
         end
      end
   end

   // Full-width signed product, floor shift, clamp to the lane range
   always_comb begin
      w_prod  = w_op_a * w_op_b;
      w_shift = w_prod >>> frac_bits;
      if ((&w_shift[PW-1:data_size-1]) || ~(|w_shift[PW-1:data_size-1]))
         w_sat = w_shift[data_size-1:0];
      else if (w_shift[PW-1])
         w_sat = {1'b1, {(data_size-1){1'b0}}};
      else
         w_sat = {1'b0, {(data_size-1){1'b1}}};
   end

   // Capture the item on accept; write one accumulator lane per multiply cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         r_start           <= '0;
         r_dense           <= '0;
         r_cost            <= '0;
         r_acc             <= '0;
         w_layer_index_out <= '0;
         w_row_index_out   <= '0;
         backprop_cost_out <= 1'b0;
         is_update_out     <= 1'b0;
         dense_type_out    <= '0;
      end else if (w_accept) begin
         r_start           <= diff_start;
         r_dense           <= diff_dense;
         r_cost            <= diff_cost;
         w_layer_index_out <= w_layer_index;
         w_row_index_out   <= w_row_index;
         backprop_cost_out <= backprop_cost;
         is_update_out     <= is_update;
         dense_type_out    <= dense_type;
      end else if (w_mul) begin
         for (int k = 0; k < size; k++) begin
            if (r_cnt == CW'(k)) r_acc[k] <= w_sat;
         end
      end
   end

endmodule

// File: tb/tb_diff_chain_stage.sv
// Bench for diff_chain_stage: directed items with hand-computed results plus
// randomized items checked every cycle against a behavioural model.
module tb_diff_chain_stage;

   localparam int SZ  = 3;
   localparam int DW  = 16;
   localparam int FB  = 8;
   localparam int DTW = 4;
   localparam int VW  = SZ * DW;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [31:0]    w_layer_index = '0;
   logic [31:0]    w_row_index = '0;
   logic           backprop_cost = 1'b0;
   logic [VW-1:0]  diff_start = '0;
   logic [VW-1:0]  diff_dense = '0;
   logic [VW-1:0]  diff_cost = '0;
   logic [DTW-1:0] dense_type = '0;
   logic           is_update = 1'b0;
   logic           out_valid;
   logic           out_ready = 1'b0;
   logic [31:0]    w_layer_index_out;
   logic [31:0]    w_row_index_out;
   logic           backprop_cost_out;
   logic           is_update_out;
   logic [DTW-1:0] dense_type_out;
   logic [VW-1:0]  diff_to_all_out;

   diff_chain_stage #(.size(SZ), .data_size(DW), .frac_bits(FB), .dense_type_size(DTW)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .w_layer_index(w_layer_index), .w_row_index(w_row_index),
      .backprop_cost(backprop_cost), .diff_start(diff_start), .diff_dense(diff_dense),
      .diff_cost(diff_cost), .dense_type(dense_type), .is_update(is_update),
      .out_valid(out_valid), .out_ready(out_ready),
      .w_layer_index_out(w_layer_index_out), .w_row_index_out(w_row_index_out),
      .backprop_cost_out(backprop_cost_out), .is_update_out(is_update_out),
      .dense_type_out(dense_type_out), .diff_to_all_out(diff_to_all_out)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      logic [VW-1:0]  res;
      logic [31:0]    li;
      logic [31:0]    ri;
      logic           bc;
      logic           up;
      logic [DTW-1:0] dt;
   } exp_t;

   function automatic logic [DW-1:0] fxmul(input logic [DW-1:0] a, input logic [DW-1:0] b);
      longint p;
      longint mx;
      logic [63:0] u;
      mx = (longint'(1) <<< (DW - 1)) - 1;
      p  = longint'($signed(a)) * longint'($signed(b));
      p  = p >>> FB;
      if (p > mx)      p = mx;
      if (p < -mx - 1) p = -mx - 1;
      u = 64'(p);
      return u[DW-1:0];
   endfunction

   function automatic exp_t model_item();
      exp_t e;
      logic [DW-1:0] v;
      e.res = '0;
      for (int k = 0; k < SZ; k++) begin
         v = fxmul(diff_start[k*DW +: DW], diff_dense[k*DW +: DW]);
         if (backprop_cost) v = fxmul(v, diff_cost[k*DW +: DW]);
         e.res[k*DW +: DW] = v;
      end
      e.li = w_layer_index;
      e.ri = w_row_index;
      e.bc = backprop_cost;
      e.up = is_update;
      e.dt = dense_type;
      return e;
   endfunction

   exp_t cur;
   bit   busy = 0;
   int   done_cyc = 0;
   int   acc_cyc = 0;
   int   hs_cyc = 0;
   int   n_out = 0;
   int   n_sent = 0;
   int   discarded = 0;

   // Compare process: sampled on the falling edge, mid-cycle
   initial begin
      forever begin
         @(negedge clk);
         if (reset) begin
            if (busy) discarded++;
            busy = 0;
         end else begin
            check("in_ready", 64'(in_ready), 64'(!busy));
            check("out_valid", 64'(out_valid), 64'(busy && cyc >= done_cyc));
            if (busy && cyc >= done_cyc) begin
               check("diff_to_all_out", 64'(diff_to_all_out), 64'(cur.res));
               check("layer_index_out", 64'(w_layer_index_out), 64'(cur.li));
               check("row_index_out", 64'(w_row_index_out), 64'(cur.ri));
               check("backprop_cost_out", 64'(backprop_cost_out), 64'(cur.bc));
               check("is_update_out", 64'(is_update_out), 64'(cur.up));
               check("dense_type_out", 64'(dense_type_out), 64'(cur.dt));
               if (out_ready) begin
                  busy   = 0;
                  hs_cyc = cyc;
                  n_out++;
               end
            end else if (!busy && in_valid) begin
               cur      = model_item();
               busy     = 1;
               acc_cyc  = cyc;
               done_cyc = cyc + 1 + (backprop_cost ? 2 * SZ : SZ);
            end
         end
      end
   end

   // ---------------- driver ----------------
   bit rnd_ordy = 0;

   task automatic tick();
      @(posedge clk);
      #1;
      if (rnd_ordy) out_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic set_item(input logic [VW-1:0] s, input logic [VW-1:0] d, input logic [VW-1:0] c,
                           input logic bc, input logic [31:0] li, input logic [31:0] ri,
                           input logic [DTW-1:0] dt, input logic up);
      diff_start    = s;
      diff_dense    = d;
      diff_cost     = c;
      backprop_cost = bc;
      w_layer_index = li;
      w_row_index   = ri;
      dense_type    = dt;
      is_update     = up;
      in_valid      = 1'b1;
   endtask

   task automatic wait_accept();
      bit a = 0;
      int n = 0;
      while (!a && n < 300) begin
         @(negedge clk);
         a = in_ready;
         tick();
         n++;
      end
      check("accept_timeout", 64'(a), 64'd1);
      if (a) n_sent++;
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int c);
      int n = 0;
      bit v = 0;
      while (!v && n < 300) begin
         @(negedge clk);
         v = out_valid;
         n++;
      end
      check("valid_timeout", 64'(v), 64'd1);
      c = cyc;
   endtask

   task automatic check_zero(input string tag);
      @(negedge clk);
      check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
      check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      check({tag, "_diff"}, 64'(diff_to_all_out), 64'd0);
      check({tag, "_tags"}, {w_layer_index_out, w_row_index_out}, 64'd0);
      check({tag, "_flags"}, 64'({backprop_cost_out, is_update_out, dense_type_out}), 64'd0);
   endtask

   function automatic logic [DW-1:0] rval();
      logic [31:0] r;
      logic [15:0] pick [5];
      pick[0] = 16'h7FFF; pick[1] = 16'h8000; pick[2] = 16'hFFFF;
      pick[3] = 16'h0001; pick[4] = 16'h0100;
      case ($urandom_range(0, 3))
         0:       r = $urandom;
         1:       r = 32'($urandom_range(0, 2047)) - 32'd1024;
         2:       r = 32'(pick[$urandom_range(0, 4)]);
         default: r = 32'($urandom_range(0, 1023)) - 32'd512;
      endcase
      return r[DW-1:0];
   endfunction

   function automatic logic [VW-1:0] rvec();
      logic [VW-1:0] v;
      for (int k = 0; k < SZ; k++) v[k*DW +: DW] = rval();
      return v;
   endfunction

   localparam logic [VW-1:0] S1 = {16'hFF00, 16'h0080, 16'h0200};
   localparam logic [VW-1:0] D1 = {16'h0300, 16'h0200, 16'h0180};
   localparam logic [VW-1:0] C1 = {16'h0080, 16'h0100, 16'h0200};

   initial begin
      int c;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      check_zero("rst");
      tick();

      // Plain chain: latency of size edges after the accept edge
      // (accept sampled one falling edge before that edge, hence +1)
      out_ready = 1'b1;
      set_item(S1, D1, C1, 1'b0, 32'h0000_0011, 32'h0000_0022, 4'h5, 1'b1);
      wait_accept();
      wait_valid(c);
      check("t1_latency", 64'(c - acc_cyc), 64'(SZ + 1));
      check("t1_result", 64'(diff_to_all_out), 64'h0000_FD00_0100_0300);
      check("t1_tags", {w_layer_index_out, w_row_index_out}, 64'h0000_0011_0000_0022);
      check("t1_flags", 64'({backprop_cost_out, is_update_out, dense_type_out}), 64'h15);
      tick();

      // Same item with the cost pass
      set_item(S1, D1, C1, 1'b1, 32'hA5A5_0001, 32'h0000_0007, 4'hC, 1'b0);
      wait_accept();
      wait_valid(c);
      check("t2_latency", 64'(c - acc_cyc), 64'(2 * SZ + 1));
      check("t2_result", 64'(diff_to_all_out), 64'h0000_FE80_0100_0600);
      tick();

      // Saturation high, saturation low, floor of -1/256
      set_item({16'hFFFF, 16'h8000, 16'h7F00}, {16'h0001, 16'h0200, 16'h7F00}, '0,
               1'b0, 32'd3, 32'd4, 4'h1, 1'b0);
      wait_accept();
      wait_valid(c);
      check("t3_saturate", 64'(diff_to_all_out), 64'h0000_FFFF_8000_7FFF);
      tick();

      // Backpressure: hold DONE for 10 cycles while a second item waits
      out_ready = 1'b0;
      set_item(S1, D1, C1, 1'b0, 32'd10, 32'd20, 4'h2, 1'b0);
      wait_accept();
      set_item({16'h0100, 16'h0100, 16'h0100}, {16'h0200, 16'hFE00, 16'h0080},
               {16'h0100, 16'h0100, 16'h0400}, 1'b1, 32'd11, 32'd21, 4'h3, 1'b1);
      wait_valid(c);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp_in_ready", 64'(in_ready), 64'd0);
         check("bp_hold", 64'(diff_to_all_out), 64'h0000_FD00_0100_0300);
      end
      tick();
      out_ready = 1'b1;
      wait_accept();
      check("bp_accept_gap", 64'(acc_cyc - hs_cyc), 64'd1);
      wait_valid(c);
      check("bp_second", 64'(diff_to_all_out), 64'h0000_0200_FE00_0200);
      tick();

      // Reset in the middle of the cost pass, then a fresh item
      set_item(S1, D1, C1, 1'b1, 32'd30, 32'd31, 4'h7, 1'b1);
      wait_accept();
      repeat (SZ + 1) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_zero("midrst");
      tick();
      set_item({16'h0040, 16'hFF80, 16'h0100}, {16'h0400, 16'h0100, 16'h0100},
               {16'hFF00, 16'h0200, 16'h0300}, 1'b1, 32'd40, 32'd41, 4'h9, 1'b0);
      wait_accept();
      wait_valid(c);
      check("post_rst", 64'(diff_to_all_out), 64'h0000_FF00_FF00_0300);
      tick();

      // Randomized back-to-back items with ready/valid stalls
      rnd_ordy = 1;
      for (int i = 0; i < 100; i++) begin
         int gap;
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) tick();
         set_item(rvec(), rvec(), rvec(), 1'($urandom_range(0, 1)), $urandom, $urandom,
                  4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
         wait_accept();
      end
      begin
         int n = 0;
         while (busy && n < 500) begin
            tick();
            n++;
         end
      end
      check("drain", 64'(busy), 64'd0);
      rnd_ordy  = 0;
      out_ready = 1'b1;
      check("item_count", 64'(n_out + discarded), 64'(n_sent));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
      $fatal(1);
   end

endmodule
